// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester, downstream and status signals of the shared QSPI port arbiter
interface mem_req_arbiter_if;
  logic        i_read_req, d_read_req, u_read_req;
  logic        i_read_w, i_read_hw, d_read_w, d_read_hw, u_read_w;
  logic [31:0] i_read_adr, d_read_adr, u_read_adr;
  logic        d_write_req, u_write_req;
  logic        d_write_w, d_write_hw, u_write_w;
  logic [31:0] d_write_adr, u_write_adr, d_write_data, u_write_data;
  logic        read_valid, write_finish, timeout_clr;
  logic        read_req, write_req;
  logic        read_w, read_hw, write_w, write_hw;
  logic [31:0] read_adr, write_adr, write_data;
  logic        i_read_done, d_read_done, d_write_done, u_read_done, u_write_done;
  logic        busy;
  logic [2:0]  grant_id;
  logic        timeout_err;

  modport master (
    output i_read_req, d_read_req, u_read_req,
    output i_read_w, i_read_hw, d_read_w, d_read_hw, u_read_w,
    output i_read_adr, d_read_adr, u_read_adr,
    output d_write_req, u_write_req, d_write_w, d_write_hw, u_write_w,
    output d_write_adr, u_write_adr, d_write_data, u_write_data,
    output read_valid, write_finish, timeout_clr,
    input  read_req, write_req, read_w, read_hw, write_w, write_hw,
    input  read_adr, write_adr, write_data,
    input  i_read_done, d_read_done, d_write_done, u_read_done, u_write_done,
    input  busy, grant_id, timeout_err
  );

  modport slave (
    input  i_read_req, d_read_req, u_read_req,
    input  i_read_w, i_read_hw, d_read_w, d_read_hw, u_read_w,
    input  i_read_adr, d_read_adr, u_read_adr,
    input  d_write_req, u_write_req, d_write_w, d_write_hw, u_write_w,
    input  d_write_adr, u_write_adr, d_write_data, u_write_data,
    input  read_valid, write_finish, timeout_clr,
    output read_req, write_req, read_w, read_hw, write_w, write_hw,
    output read_adr, write_adr, write_data,
    output i_read_done, d_read_done, d_write_done, u_read_done, u_write_done,
    output busy, grant_id, timeout_err
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - fixed-priority sequencer of CPU/UART accesses onto the single QSPI memory port
module mem_req_arbiter #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int TCW         = 13
) (
  input logic              clk,
  input logic              rst_n,
  mem_req_arbiter_if.slave bus
);
  localparam int NSRC = 5;
  localparam int I_RD = 0;
  localparam int D_RD = 1;
  localparam int D_WR = 2;
  localparam int U_RD = 3;
  localparam int U_WR = 4;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_RD = 2'd1, WAIT_WR = 2'd2} state_t;
  state_t state, state_nxt;

  logic [NSRC-1:0] req_vec, in_w, in_hw;
  logic [31:0]     in_adr  [NSRC];
  logic [31:0]     in_data [NSRC];

  logic [NSRC-1:0] pend, cap_w, cap_hw;
  logic [31:0]     cap_adr  [NSRC];
  logic [31:0]     cap_data [NSRC];

  logic [TCW-1:0]  tmo_cnt;
  logic [2:0]      gnt_id;
  logic [NSRC-1:0] done_q;
  logic            err_q;
  logic            rd_w_q, rd_hw_q, wr_w_q, wr_hw_q;
  logic [31:0]     rd_adr_q, wr_adr_q, wr_data_q;

  logic            win_valid, win_is_wr;
  logic [2:0]      win_idx;
  logic            grant, completion, tmo_hit, finish, abort;
  logic            read_req_c, write_req_c, busy_c;

  // Source index order doubles as priority: higher index wins.
  assign req_vec = {bus.u_write_req, bus.u_read_req, bus.d_write_req, bus.d_read_req, bus.i_read_req};
  assign in_w    = {bus.u_write_w, bus.u_read_w, bus.d_write_w, bus.d_read_w, bus.i_read_w};
  assign in_hw   = {1'b0, 1'b0, bus.d_write_hw, bus.d_read_hw, bus.i_read_hw};

  assign in_adr[I_RD]  = bus.i_read_adr;
  assign in_adr[D_RD]  = bus.d_read_adr;
  assign in_adr[D_WR]  = bus.d_write_adr;
  assign in_adr[U_RD]  = bus.u_read_adr;
  assign in_adr[U_WR]  = bus.u_write_adr;
  assign in_data[I_RD] = '0;
  assign in_data[D_RD] = '0;
  assign in_data[D_WR] = bus.d_write_data;
  assign in_data[U_RD] = '0;
  assign in_data[U_WR] = bus.u_write_data;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (pend[k]) begin
        win_valid = 1'b1;
        win_idx   = 3'(k);
      end
    end
    win_is_wr = (win_idx == 3'(D_WR)) || (win_idx == 3'(U_WR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = win_is_wr ? WAIT_WR : WAIT_RD;
      WAIT_RD: if (bus.read_valid || tmo_hit) state_nxt = IDLE;
      WAIT_WR: if (bus.write_finish || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter is cleared at grant, so a zero count marks the first wait cycle.
  always_comb begin
    busy_c      = (state != IDLE);
    read_req_c  = (state == WAIT_RD) && (tmo_cnt == '0);
    write_req_c = (state == WAIT_WR) && (tmo_cnt == '0);
    grant       = (state == IDLE) && win_valid;
    completion  = ((state == WAIT_RD) && bus.read_valid) ||
                  ((state == WAIT_WR) && bus.write_finish);
    tmo_hit     = busy_c && (tmo_cnt == TMO_LAST);
    finish      = completion || tmo_hit;
    abort       = tmo_hit && !completion;
  end

  // Pending clears at grant so the served source can queue a fresh request meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      cap_w  <= '0;
      cap_hw <= '0;
      for (int k = 0; k < NSRC; k++) begin
        cap_adr[k]  <= '0;
        cap_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSRC; k++) begin
        if (grant && (win_idx == 3'(k))) begin
          pend[k] <= 1'b0;
        end else if (req_vec[k] && !pend[k]) begin
          pend[k]     <= 1'b1;
          cap_w[k]    <= in_w[k];
          cap_hw[k]   <= in_hw[k];
          cap_adr[k]  <= in_adr[k];
          cap_data[k] <= in_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      gnt_id    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rd_w_q    <= 1'b0;
      rd_hw_q   <= 1'b0;
      rd_adr_q  <= '0;
      wr_w_q    <= 1'b0;
      wr_hw_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
    end else begin
      if (grant) begin
        tmo_cnt <= '0;
        gnt_id  <= win_idx + 3'd1;
        if (win_is_wr) begin
          wr_w_q    <= cap_w[win_idx];
          wr_hw_q   <= cap_hw[win_idx];
          wr_adr_q  <= cap_adr[win_idx];
          wr_data_q <= cap_data[win_idx];
        end else begin
          rd_w_q    <= cap_w[win_idx];
          rd_hw_q   <= cap_hw[win_idx];
          rd_adr_q  <= cap_adr[win_idx];
        end
      end else begin
        if (busy_c) tmo_cnt <= tmo_cnt + TCW'(1);
        if (finish) gnt_id <= '0;
      end

      for (int k = 0; k < NSRC; k++) begin
        done_q[k] <= finish && (gnt_id == 3'(k + 1));
      end

      if (abort)                err_q <= 1'b1;
      else if (bus.timeout_clr) err_q <= 1'b0;
    end
  end

  assign bus.read_req     = read_req_c;
  assign bus.write_req    = write_req_c;
  assign bus.busy         = busy_c;
  assign bus.grant_id     = gnt_id;
  assign bus.timeout_err  = err_q;
  assign bus.read_w       = rd_w_q;
  assign bus.read_hw      = rd_hw_q;
  assign bus.read_adr     = rd_adr_q;
  assign bus.write_w      = wr_w_q;
  assign bus.write_hw     = wr_hw_q;
  assign bus.write_adr    = wr_adr_q;
  assign bus.write_data   = wr_data_q;
  assign bus.i_read_done  = done_q[I_RD];
  assign bus.d_read_done  = done_q[D_RD];
  assign bus.d_write_done = done_q[D_WR];
  assign bus.u_read_done  = done_q[U_RD];
  assign bus.u_write_done = done_q[U_WR];
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [4:0] dones;

  mem_req_arbiter_if bus ();

  mem_req_arbiter #(.TIMEOUT_CYC(8), .TCW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {u_wr, u_rd, d_wr, d_rd, i_rd}
  assign dones = {bus.u_write_done, bus.u_read_done, bus.d_write_done, bus.d_read_done, bus.i_read_done};

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drop_pulses();
    bus.i_read_req = 0; bus.d_read_req = 0; bus.u_read_req = 0;
    bus.d_write_req = 0; bus.u_write_req = 0;
    bus.read_valid = 0; bus.write_finish = 0; bus.timeout_clr = 0;
  endtask

  task automatic idle_inputs();
    drop_pulses();
    bus.i_read_w = 0; bus.i_read_hw = 0; bus.d_read_w = 0; bus.d_read_hw = 0; bus.u_read_w = 0;
    bus.i_read_adr = 0; bus.d_read_adr = 0; bus.u_read_adr = 0;
    bus.d_write_w = 0; bus.d_write_hw = 0; bus.u_write_w = 0;
    bus.d_write_adr = 0; bus.u_write_adr = 0; bus.d_write_data = 0; bus.u_write_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cyc(3);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    total++; if (bus.grant_id !== 3'd0) begin bad++; $display("FAIL rst_grant_id got=%0h exp=0", bus.grant_id); end
    total++; if ({bus.read_req, bus.write_req} !== 2'b00) begin bad++; $display("FAIL rst_reqs got=%0b exp=00", {bus.read_req, bus.write_req}); end
    total++; if (dones !== 5'b0) begin bad++; $display("FAIL rst_dones got=%0b exp=0", dones); end
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%0h exp=0", bus.timeout_err); end
    total++; if ({bus.read_adr, bus.write_adr, bus.write_data} !== 96'h0) begin bad++; $display("FAIL rst_attrs got=%0h exp=0", {bus.read_adr, bus.write_adr, bus.write_data}); end
    rst_n = 1;
    cyc(2);
  endtask

  task automatic test_single_read();
    bus.d_read_req = 1; bus.d_read_adr = 32'h0000_0100; bus.d_read_w = 1; bus.d_read_hw = 0;
    cyc(); drop_pulses();
    total++; if (bus.read_req !== 1'b0) begin bad++; $display("FAIL t1_early_req got=%0h exp=0", bus.read_req); end
    cyc();
    total++; if (bus.read_req !== 1'b1) begin bad++; $display("FAIL t1_read_req got=%0h exp=1", bus.read_req); end
    total++; if (bus.write_req !== 1'b0) begin bad++; $display("FAIL t1_write_req got=%0h exp=0", bus.write_req); end
    total++; if (bus.read_adr !== 32'h100) begin bad++; $display("FAIL t1_read_adr got=%0h exp=100", bus.read_adr); end
    total++; if ({bus.read_w, bus.read_hw} !== 2'b10) begin bad++; $display("FAIL t1_size got=%0b exp=10", {bus.read_w, bus.read_hw}); end
    total++; if (bus.grant_id !== 3'd2) begin bad++; $display("FAIL t1_grant_id got=%0d exp=2", bus.grant_id); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL t1_busy got=%0h exp=1", bus.busy); end
    cyc();
    total++; if (bus.read_req !== 1'b0) begin bad++; $display("FAIL t1_req_one_cycle got=%0h exp=0", bus.read_req); end
    cyc(4);
    bus.read_valid = 1;
    total++; if (dones !== 5'b0) begin bad++; $display("FAIL t1_done_early got=%0b exp=0", dones); end
    cyc(); drop_pulses();
    total++; if (dones !== 5'b00010) begin bad++; $display("FAIL t1_done got=%0b exp=00010", dones); end
    total++; if ({bus.busy, bus.grant_id} !== 4'b0) begin bad++; $display("FAIL t1_release got=%0h exp=0", {bus.busy, bus.grant_id}); end
    cyc();
    total++; if (dones !== 5'b0) begin bad++; $display("FAIL t1_done_one_cycle got=%0b exp=0", dones); end
  endtask

  task automatic test_priority();
    bus.i_read_req = 1; bus.i_read_adr = 32'h1000; bus.i_read_w = 0; bus.i_read_hw = 1;
    bus.d_write_req = 1; bus.d_write_adr = 32'h2000; bus.d_write_data = 32'hA5A5_0001; bus.d_write_w = 0; bus.d_write_hw = 1;
    bus.u_read_req = 1; bus.u_read_adr = 32'h3000; bus.u_read_w = 1;
    cyc(); drop_pulses();
    cyc();
    total++; if ({bus.read_req, bus.write_req, bus.grant_id} !== 5'b10_100) begin bad++; $display("FAIL t2_first got=%0b exp=10100", {bus.read_req, bus.write_req, bus.grant_id}); end
    total++; if ({bus.read_adr, bus.read_w, bus.read_hw} !== {32'h3000, 2'b10}) begin bad++; $display("FAIL t2_u_read_attr got=%0h", {bus.read_adr, bus.read_w, bus.read_hw}); end
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if (dones !== 5'b01000) begin bad++; $display("FAIL t2_u_read_done got=%0b exp=01000", dones); end
    total++; if ({bus.read_req, bus.write_req} !== 2'b00) begin bad++; $display("FAIL t2_gap got=%0b exp=00", {bus.read_req, bus.write_req}); end
    cyc();
    total++; if ({bus.read_req, bus.write_req, bus.grant_id} !== 5'b01_011) begin bad++; $display("FAIL t2_second got=%0b exp=01011", {bus.read_req, bus.write_req, bus.grant_id}); end
    total++; if ({bus.write_adr, bus.write_data, bus.write_w, bus.write_hw} !== {32'h2000, 32'hA5A5_0001, 2'b01}) begin bad++; $display("FAIL t2_d_write_attr got=%0h", {bus.write_adr, bus.write_data, bus.write_w, bus.write_hw}); end
    bus.write_finish = 1;
    cyc(); drop_pulses();
    total++; if (dones !== 5'b00100) begin bad++; $display("FAIL t2_d_write_done got=%0b exp=00100", dones); end
    cyc();
    total++; if ({bus.read_req, bus.write_req, bus.grant_id} !== 5'b10_001) begin bad++; $display("FAIL t2_third got=%0b exp=10001", {bus.read_req, bus.write_req, bus.grant_id}); end
    total++; if ({bus.read_adr, bus.read_w, bus.read_hw} !== {32'h1000, 2'b01}) begin bad++; $display("FAIL t2_i_read_attr got=%0h", {bus.read_adr, bus.read_w, bus.read_hw}); end
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.busy} !== 6'b00001_0) begin bad++; $display("FAIL t2_i_read_done got=%0b exp=000010", {dones, bus.busy}); end
  endtask

  task automatic test_dup_write();
    int wr_cnt;
    bus.d_write_req = 1; bus.d_write_adr = 32'h200; bus.d_write_data = 32'hDEAD_BEEF; bus.d_write_w = 1; bus.d_write_hw = 0;
    cyc();
    bus.d_write_adr = 32'h300; bus.d_write_data = 32'h1234_5678;
    cyc(); drop_pulses();
    total++; if (bus.write_req !== 1'b1) begin bad++; $display("FAIL t3_write_req got=%0h exp=1", bus.write_req); end
    total++; if (bus.write_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t3_write_data got=%0h exp=deadbeef", bus.write_data); end
    total++; if (bus.write_adr !== 32'h200) begin bad++; $display("FAIL t3_write_adr got=%0h exp=200", bus.write_adr); end
    bus.write_finish = 1;
    cyc(); drop_pulses();
    total++; if (dones !== 5'b00100) begin bad++; $display("FAIL t3_done got=%0b exp=00100", dones); end
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (bus.write_req || bus.busy) wr_cnt++;
    end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL t3_second_write got=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_timeout();
    bus.u_write_req = 1; bus.u_write_adr = 32'h4000; bus.u_write_data = 32'hCAFE_F00D; bus.u_write_w = 1;
    cyc(); drop_pulses();
    cyc();
    total++; if ({bus.write_req, bus.grant_id} !== 4'b1_101) begin bad++; $display("FAIL t4_grant got=%0b exp=1101", {bus.write_req, bus.grant_id}); end
    cyc(7);
    total++; if ({dones, bus.timeout_err, bus.busy} !== 7'b00000_0_1) begin bad++; $display("FAIL t4_before got=%0b exp=0000001", {dones, bus.timeout_err, bus.busy}); end
    cyc();
    total++; if (dones !== 5'b10000) begin bad++; $display("FAIL t4_done got=%0b exp=10000", dones); end
    total++; if ({bus.timeout_err, bus.busy, bus.grant_id} !== 5'b1_0_000) begin bad++; $display("FAIL t4_err got=%0b exp=10000", {bus.timeout_err, bus.busy, bus.grant_id}); end
    cyc();
    total++; if ({dones, bus.timeout_err} !== 6'b00000_1) begin bad++; $display("FAIL t4_sticky got=%0b exp=000001", {dones, bus.timeout_err}); end
    bus.timeout_clr = 1;
    cyc(); drop_pulses();
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL t4_clr got=%0h exp=0", bus.timeout_err); end
  endtask

  task automatic test_timeout_edges();
    bus.u_read_req = 1; bus.u_read_adr = 32'h4400; bus.u_read_w = 0;
    cyc(); drop_pulses();
    cyc(8);
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.timeout_err} !== 6'b01000_0) begin bad++; $display("FAIL t4b_late_complete got=%0b exp=010000", {dones, bus.timeout_err}); end
    bus.d_read_req = 1; bus.d_read_adr = 32'h4800;
    cyc(); drop_pulses();
    cyc(8);
    bus.timeout_clr = 1;
    cyc();
    total++; if ({dones, bus.timeout_err} !== 6'b00010_1) begin bad++; $display("FAIL t4c_clr_vs_abort got=%0b exp=000101", {dones, bus.timeout_err}); end
    cyc(); drop_pulses();
    total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL t4c_clr_after got=%0h exp=0", bus.timeout_err); end
  endtask

  task automatic test_stray();
    bus.read_valid = 1;
    cyc(); drop_pulses();
    bus.write_finish = 1;
    total++; if ({dones, bus.busy} !== 6'b0) begin bad++; $display("FAIL t5_idle_rv got=%0b exp=0", {dones, bus.busy}); end
    cyc(); drop_pulses();
    total++; if ({dones, bus.busy, bus.read_req, bus.write_req} !== 8'b0) begin bad++; $display("FAIL t5_idle_wf got=%0b exp=0", {dones, bus.busy, bus.read_req, bus.write_req}); end
    bus.d_read_req = 1; bus.d_read_adr = 32'h5000;
    cyc(); drop_pulses();
    cyc(2);
    bus.write_finish = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.busy, bus.grant_id} !== 9'b00000_1_010) begin bad++; $display("FAIL t5_wrong_type got=%0b exp=000001010", {dones, bus.busy, bus.grant_id}); end
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.busy} !== 6'b00010_0) begin bad++; $display("FAIL t5_real_done got=%0b exp=000100", {dones, bus.busy}); end
  endtask

  task automatic test_back_to_back();
    bus.d_read_req = 1; bus.d_read_adr = 32'h500; bus.d_read_w = 1; bus.d_read_hw = 0;
    cyc(); drop_pulses();
    cyc(2);
    bus.d_read_req = 1; bus.d_read_adr = 32'h600; bus.d_read_w = 0; bus.d_read_hw = 1;
    cyc(); drop_pulses();
    total++; if (bus.read_adr !== 32'h500) begin bad++; $display("FAIL t7_hold_adr got=%0h exp=500", bus.read_adr); end
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.read_req} !== 6'b00010_0) begin bad++; $display("FAIL t7_first_done got=%0b exp=000100", {dones, bus.read_req}); end
    cyc();
    total++; if ({bus.read_req, bus.grant_id} !== 4'b1_010) begin bad++; $display("FAIL t7_reissue got=%0b exp=1010", {bus.read_req, bus.grant_id}); end
    total++; if ({bus.read_adr, bus.read_w, bus.read_hw} !== {32'h600, 2'b01}) begin bad++; $display("FAIL t7_new_attr got=%0h", {bus.read_adr, bus.read_w, bus.read_hw}); end
    bus.read_valid = 1;
    cyc(); drop_pulses();
    total++; if ({dones, bus.busy} !== 6'b00010_0) begin bad++; $display("FAIL t7_second_done got=%0b exp=000100", {dones, bus.busy}); end
  endtask

  task automatic test_reset_mid();
    int events;
    bus.i_read_req = 1; bus.i_read_adr = 32'h700; bus.i_read_w = 1; bus.i_read_hw = 0;
    cyc(); drop_pulses();
    cyc(2);
    bus.d_read_req = 1; bus.d_read_adr = 32'h800;
    cyc(); drop_pulses();
    rst_n = 0;
    #1;
    total++; if ({bus.busy, bus.grant_id, bus.read_req, bus.write_req} !== 6'b0) begin bad++; $display("FAIL t6_ctrl got=%0b exp=0", {bus.busy, bus.grant_id, bus.read_req, bus.write_req}); end
    total++; if ({bus.read_adr, bus.read_w, bus.read_hw, dones} !== 39'h0) begin bad++; $display("FAIL t6_attrs got=%0h exp=0", {bus.read_adr, bus.read_w, bus.read_hw, dones}); end
    cyc(2);
    rst_n = 1;
    events = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (bus.read_req || bus.write_req || bus.busy || (dones != 5'b0)) events++;
    end
    total++; if (events !== 0) begin bad++; $display("FAIL t6_after_release got=%0d exp=0", events); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_dup_write();
    test_timeout();
    test_timeout_edges();
    test_stray();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
